// File: rtl/fetch_pkg.sv
// Shared types and defaults for the instruction fetch stage.
package fetch_pkg;

  localparam int AW_DEF  = 20;
  localparam int DW_DEF  = 20;
  localparam int OPW_DEF = 4;
  localparam logic [OPW_DEF-1:0] HALT_OP_DEF = 4'hF;

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_VALID,
    S_HALT
  } fetch_state_e;

  // Opcode lives in the top OPW bits of an instruction word.
  function automatic logic [OPW_DEF-1:0] opcode_of(input logic [DW_DEF-1:0] word);
    return word[DW_DEF-1 -: OPW_DEF];
  endfunction

endpackage

// File: rtl/instr_fetch.sv
// Fetch stage: owns the PC, drives the program ROM, and hands instructions
// to decode over valid/ready. Stops on a halt opcode until redirected.
module instr_fetch
  import fetch_pkg::*;
#(
  parameter int AW  = AW_DEF,
  parameter int DW  = DW_DEF,
  parameter int OPW = OPW_DEF,
  parameter logic [OPW-1:0] HALT_OP  = OPW'(HALT_OP_DEF),
  parameter logic [AW-1:0]  RESET_PC = '0,
  parameter int CW  = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  output logic          rom_load,
  output logic [AW-1:0] rom_addr,
  input  logic [DW-1:0] rom_data,
  output logic [DW-1:0] instr,
  output logic [AW-1:0] instr_pc,
  output logic          instr_valid,
  input  logic          instr_ready,
  input  logic          redirect_valid,
  input  logic [AW-1:0] redirect_addr,
  output logic          halted,
  output logic [CW-1:0] fetch_count,
  output fetch_state_e  dbg_state
);

  // Handshake: a transfer to decode happens on a rising edge where
  // instr_valid && instr_ready; instr/instr_pc are held stable until then.

  fetch_state_e  state_q;
  logic [AW-1:0] pc_q;
  logic [DW-1:0] ir_q;
  logic [AW-1:0] ipc_q;
  logic          valid_q;
  logic [CW-1:0] count_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      pc_q    <= RESET_PC;
      ir_q    <= '0;
      ipc_q   <= '0;
      valid_q <= 1'b0;
      count_q <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            if (redirect_valid) pc_q <= redirect_addr;
            state_q <= S_REQ;
          end
        end
        S_REQ: begin
          if (redirect_valid) pc_q <= redirect_addr;
          else                state_q <= S_WAIT;
        end
        S_WAIT: begin
          // A redirect drops the word the ROM is returning for the old pc.
          if (redirect_valid) begin
            pc_q    <= redirect_addr;
            state_q <= S_REQ;
          end else begin
            ir_q    <= rom_data;
            ipc_q   <= pc_q;
            pc_q    <= pc_q + AW'(1);
            valid_q <= 1'b1;
            state_q <= S_VALID;
          end
        end
        S_VALID: begin
          if (instr_ready) begin
            count_q <= count_q + CW'(1);
            valid_q <= 1'b0;
          end
          if (redirect_valid) begin
            valid_q <= 1'b0;
            pc_q    <= redirect_addr;
            state_q <= S_REQ;
          end else if (instr_ready) begin
            state_q <= (ir_q[DW-1 -: OPW] == HALT_OP) ? S_HALT : S_REQ;
          end
        end
        S_HALT: begin
          if (redirect_valid) begin
            pc_q    <= redirect_addr;
            state_q <= S_REQ;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign rom_load    = (state_q == S_REQ);
  assign rom_addr    = pc_q;
  assign instr       = ir_q;
  assign instr_pc    = ipc_q;
  assign instr_valid = valid_q;
  assign halted      = (state_q == S_HALT);
  assign fetch_count = count_q;
  assign dbg_state   = state_q;

endmodule
